// File: rtl/gcd_equiv_miter_p_pkg.sv
// Shared definitions for the parametrised GCD equivalence miter.
// The algorithm selectors are used by gcd_core_p. The state type is used by
// the miter FSM.
package gcd_miter_pkg;

  localparam int MODE_SUB    = 0;  // subtract the smaller operand from the larger
  localparam int MODE_SWAP   = 1;  // subtract A-B, swap the operands when A<B
  localparam int MODE_MUTANT = 2;  // SUB with an inverted result LSB, a deliberate bug

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/gcd_equiv_miter_p_if.sv
// Bundles the request and status signals of gcd_equiv_miter_p.
//   master : drives start/a_in/b_in and observes the status (testbench side)
//   slave  : the miter itself
// Ports:
//   start, a_in, b_in            launch request and operand pair
//   busy, done, result           run status and core A result
//   nequiv, timeout              sticky mismatch and abort flags
//   lat_a, lat_b, pass_count     per-core latency and matching-run count
interface gcd_equiv_miter_p_if #(
  parameter int WIDTH = 6,
  parameter int CNT_W = 9
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             nequiv;
  logic             timeout;
  logic [CNT_W-1:0] lat_a;
  logic [CNT_W-1:0] lat_b;
  logic [15:0]      pass_count;

  modport master (
    output start, a_in, b_in,
    input  busy, done, result, nequiv, timeout, lat_a, lat_b, pass_count
  );

  modport slave (
    input  start, a_in, b_in,
    output busy, done, result, nequiv, timeout, lat_a, lat_b, pass_count
  );
endinterface

// File: rtl/gcd_equiv_miter_p_core.sv
// A single iterative GCD engine. It performs one step per enabled cycle.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   en           advance one step (ignored while load is high)
//   load         capture a_in/b_in and clear valid
//   a_in, b_in   operands
//   out, valid   result and completion flag, held until the next load
module gcd_core_p
  import gcd_miter_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int MODE  = MODE_SUB
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] out,
  output logic             valid
);

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] fin;
  logic             term;

  // gcd(x,0) = x and gcd(0,0) = 0 both come from A|B.
  assign term = (a_q == '0) || (b_q == '0) || (a_q == b_q);

  always_comb begin
    fin = a_q | b_q;
    if (MODE == MODE_MUTANT) begin
      fin[0] = ~fin[0];
    end
  end

  // A finished core can be stepped again safely. Its operands are terminal,
  // so each repeated step produces the same out value.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      out   <= '0;
      valid <= 1'b0;
    end else if (load) begin
      a_q   <= a_in;
      b_q   <= b_in;
      out   <= '0;
      valid <= 1'b0;
    end else if (en) begin
      if (term) begin
        out   <= fin;
        valid <= 1'b1;
      end else if (a_q > b_q) begin
        a_q <= a_q - b_q;
      end else if (MODE == MODE_SWAP) begin
        a_q <= b_q;
        b_q <= a_q;
      end else begin
        b_q <= b_q - a_q;
      end
    end
  end

endmodule

// File: rtl/gcd_equiv_miter_p.sv
// Equivalence miter. It runs two GCD cores on the same operands, compares the
// results, records the latency of each core, and aborts runs that take longer
// than TIMEOUT cycles.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   bus          gcd_equiv_miter_p_if.slave (start/operands in, status out)
//
//   state | meaning
//   IDLE  | waiting for start; cores hold the last result
//   RUN   | cores stepping; a finished core is frozen until its partner finishes
module gcd_equiv_miter_p
  import gcd_miter_pkg::*;
#(
  parameter int  WIDTH   = 6,
  parameter int  MODE_A  = MODE_SUB,
  parameter int  MODE_B  = MODE_SWAP,
  parameter int  TIMEOUT = 256,
  localparam int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input logic clk,
  input logic reset,
  gcd_equiv_miter_p_if.slave bus
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_a, out_b, ld_a, ld_b;
  logic             valid_a, valid_b, en_a, en_b, core_load, busy;
  logic             accept, finish, abort, at_limit;
  logic [CNT_W-1:0] cyc_q, lat_a_q, lat_b_q;
  logic [WIDTH-1:0] result_q;
  logic             done_q, nequiv_q, timeout_q;
  logic [15:0]      pass_q;

  // A start that coincides with the done pulse is dropped. The run that just
  // ended is still being reported in that cycle.
  assign accept   = (state_q == IDLE) && bus.start && !done_q;
  assign finish   = (state_q == RUN) && valid_a && valid_b;
  assign at_limit = (cyc_q == CNT_W'(TIMEOUT - 1));
  assign abort    = (state_q == RUN) && !(valid_a && valid_b) && at_limit;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (finish || abort) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    core_load = 1'b0;
    en_a      = 1'b0;
    en_b      = 1'b0;
    case (state_q)
      IDLE: core_load = accept;
      RUN: begin
        busy      = 1'b1;
        core_load = abort;  // an aborted run loads zeros, which clears the cores
        en_a      = !(valid_a && !valid_b);
        en_b      = !(valid_b && !valid_a);
      end
      default: ;
    endcase
  end

  assign ld_a = (state_q == IDLE) ? bus.a_in : '0;
  assign ld_b = (state_q == IDLE) ? bus.b_in : '0;

  gcd_core_p #(.WIDTH(WIDTH), .MODE(MODE_A)) u_core_a (
    .clk   (clk),
    .reset (reset),
    .en    (en_a),
    .load  (core_load),
    .a_in  (ld_a),
    .b_in  (ld_b),
    .out   (out_a),
    .valid (valid_a)
  );

  gcd_core_p #(.WIDTH(WIDTH), .MODE(MODE_B)) u_core_b (
    .clk   (clk),
    .reset (reset),
    .en    (en_b),
    .load  (core_load),
    .a_in  (ld_a),
    .b_in  (ld_b),
    .out   (out_b),
    .valid (valid_b)
  );

  // The latency counters start at 1 so that the start edge itself is counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q     <= '0;
      lat_a_q   <= '0;
      lat_b_q   <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
      nequiv_q  <= 1'b0;
      timeout_q <= 1'b0;
      pass_q    <= '0;
    end else begin
      done_q <= finish || abort;
      if (accept) begin
        cyc_q   <= '0;
        lat_a_q <= CNT_W'(1);
        lat_b_q <= CNT_W'(1);
      end else if ((state_q == RUN) && !abort) begin
        cyc_q <= cyc_q + CNT_W'(1);
        if (!valid_a) lat_a_q <= lat_a_q + CNT_W'(1);
        if (!valid_b) lat_b_q <= lat_b_q + CNT_W'(1);
      end
      if (finish) begin
        result_q <= out_a;
        if (out_a != out_b) begin
          nequiv_q <= 1'b1;
        end else if (pass_q != 16'hFFFF) begin
          pass_q <= pass_q + 16'd1;
        end
      end
      if (abort) timeout_q <= 1'b1;
    end
  end

  assign bus.busy       = busy;
  assign bus.done       = done_q;
  assign bus.result     = result_q;
  assign bus.nequiv     = nequiv_q;
  assign bus.timeout    = timeout_q;
  assign bus.lat_a      = lat_a_q;
  assign bus.lat_b      = lat_b_q;
  assign bus.pass_count = pass_q;

endmodule

// File: tb/tb_gcd_equiv_miter_p.sv
// Testbench for gcd_equiv_miter_p. It uses three instances:
//   dut0 default modes, dut1 with a mutant core B, dut2 with a short timeout.
module tb_gcd_equiv_miter_p;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   pc0    = 0;

  always #5 clk = ~clk;

  gcd_equiv_miter_p_if #(.WIDTH(6), .CNT_W(9)) if0 ();
  gcd_equiv_miter_p_if #(.WIDTH(6), .CNT_W(9)) if1 ();
  gcd_equiv_miter_p_if #(.WIDTH(6), .CNT_W(4)) if2 ();

  gcd_equiv_miter_p #(.WIDTH(6), .MODE_A(0), .MODE_B(1), .TIMEOUT(256)) dut0 (
    .clk(clk), .reset(reset), .bus(if0));
  gcd_equiv_miter_p #(.WIDTH(6), .MODE_A(0), .MODE_B(2), .TIMEOUT(256)) dut1 (
    .clk(clk), .reset(reset), .bus(if1));
  gcd_equiv_miter_p #(.WIDTH(6), .MODE_A(0), .MODE_B(1), .TIMEOUT(8)) dut2 (
    .clk(clk), .reset(reset), .bus(if2));

  typedef struct {
    logic [5:0] a;
    logic [5:0] b;
    int         res;
    int         la;
    int         lb;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference GCD using Euclid's remainder form.
  function automatic int gcd_ref(input int a, input int b);
    int x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Latency derived from the Euclid quotients q_i. SUB performs sum(q)-1
  // subtractions and then one terminal step. SWAP adds one swap per nonzero
  // remainder, and one more when it starts with A<B. The start edge adds one.
  function automatic int lat_ref(input int a, input int b, input bit swap_mode);
    int x, y, q, r, n;
    bit fin;
    if (a == 0 || b == 0 || a == b) return 2;
    n   = 1;
    if (swap_mode && a < b) n++;
    x   = (a > b) ? a : b;
    y   = (a > b) ? b : a;
    fin = 1'b0;
    while (!fin) begin
      q = x / y;
      r = x % y;
      if (r == 0) begin
        n   = n + q;
        fin = 1'b1;
      end else begin
        n = n + (swap_mode ? q + 1 : q);
        x = y;
        y = r;
      end
    end
    return n;
  endfunction

  function automatic logic done_of(input int w);
    case (w)
      0:       return if0.done;
      1:       return if1.done;
      default: return if2.done;
    endcase
  endfunction

  function automatic logic busy_of(input int w);
    case (w)
      0:       return if0.busy;
      1:       return if1.busy;
      default: return if2.busy;
    endcase
  endfunction

  task automatic launch(input int w, input logic [5:0] a, input logic [5:0] b);
    @(negedge clk);
    case (w)
      0:       begin if0.a_in = a; if0.b_in = b; if0.start = 1'b1; end
      1:       begin if1.a_in = a; if1.b_in = b; if1.start = 1'b1; end
      default: begin if2.a_in = a; if2.b_in = b; if2.start = 1'b1; end
    endcase
    @(negedge clk);
    if0.start = 1'b0;
    if1.start = 1'b0;
    if2.start = 1'b0;
  endtask

  // Waits for done within a fixed cycle budget and counts the busy cycles
  // seen before it. Optionally raises start during the done cycle.
  task automatic wait_done(input int w, input bit poke, output int bc);
    bit seen;
    seen = 1'b0;
    bc   = 0;
    for (int n = 0; n < 400 && !seen; n++) begin
      if (done_of(w)) seen = 1'b1;
      else begin
        if (busy_of(w)) bc++;
        @(negedge clk);
      end
    end
    check("done_seen", {31'd0, seen}, 1);
    check("busy_low_at_done", {31'd0, busy_of(w)}, 0);
    if (poke) begin
      if0.a_in  = 6'd5;
      if0.b_in  = 6'd5;
      if0.start = 1'b1;
    end
    @(negedge clk);
    if0.start = 1'b0;
    check("done_one_cycle", {31'd0, done_of(w)}, 0);
    if (poke) check("start_at_done_ignored", {31'd0, if0.busy}, 0);
  endtask

  task automatic run0(input logic [5:0] a, input logic [5:0] b, input bit poke,
                      input int res, input int la, input int lb);
    int bc;
    launch(0, a, b);
    wait_done(0, poke, bc);
    pc0++;
    check("result0", {26'd0, if0.result}, res);
    check("lat_a0", {23'd0, if0.lat_a}, la);
    check("lat_b0", {23'd0, if0.lat_b}, lb);
    check("busy_cycles0", bc, (la > lb) ? la : lb);
    check("pass_count0", {16'd0, if0.pass_count}, pc0);
    check("nequiv0", {31'd0, if0.nequiv}, 0);
  endtask

  task automatic check_zero0(input string tag);
    check({tag, "_busy"}, {31'd0, if0.busy}, 0);
    check({tag, "_done"}, {31'd0, if0.done}, 0);
    check({tag, "_result"}, {26'd0, if0.result}, 0);
    check({tag, "_nequiv"}, {31'd0, if0.nequiv}, 0);
    check({tag, "_timeout"}, {31'd0, if0.timeout}, 0);
    check({tag, "_lat_a"}, {23'd0, if0.lat_a}, 0);
    check({tag, "_lat_b"}, {23'd0, if0.lat_b}, 0);
    check({tag, "_pass"}, {16'd0, if0.pass_count}, 0);
  endtask

  initial begin
    logic [5:0] ra, rb;
    int bc;

    if0.start = 1'b0; if0.a_in = '0; if0.b_in = '0;
    if1.start = 1'b0; if1.a_in = '0; if1.b_in = '0;
    if2.start = 1'b0; if2.a_in = '0; if2.b_in = '0;

    vecs[0] = '{a: 6'd12, b: 6'd8,  res: 4, la: 4,  lb: 5};
    vecs[1] = '{a: 6'd0,  b: 6'd5,  res: 5, la: 2,  lb: 2};
    vecs[2] = '{a: 6'd7,  b: 6'd7,  res: 7, la: 2,  lb: 2};
    vecs[3] = '{a: 6'd8,  b: 6'd12, res: 4, la: 4,  lb: 6};
    vecs[4] = '{a: 6'd5,  b: 6'd0,  res: 5, la: 2,  lb: 2};
    vecs[5] = '{a: 6'd0,  b: 6'd0,  res: 0, la: 2,  lb: 2};
    vecs[6] = '{a: 6'd63, b: 6'd1,  res: 1, la: 64, lb: 64};

    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_zero0("reset");
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run0(vecs[i].a, vecs[i].b, 1'b0, vecs[i].res, vecs[i].la, vecs[i].lb);
    end

    for (int i = 0; i < 30; i++) begin
      ra = 6'($urandom_range(0, 63));
      rb = 6'($urandom_range(0, 63));
      run0(ra, rb, 1'b0, gcd_ref(int'(ra), int'(rb)),
           lat_ref(int'(ra), int'(rb), 1'b0), lat_ref(int'(ra), int'(rb), 1'b1));
    end

    // A start raised during the done cycle must not launch a run.
    run0(6'd20, 6'd15, 1'b1, gcd_ref(20, 15), lat_ref(20, 15, 1'b0), lat_ref(20, 15, 1'b1));

    // A second start during RUN is ignored, so the 63/1 result is reported.
    launch(0, 6'd63, 6'd1);
    repeat (3) @(negedge clk);
    if0.a_in = 6'd10; if0.b_in = 6'd4; if0.start = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    wait_done(0, 1'b0, bc);
    pc0++;
    check("restart_result", {26'd0, if0.result}, 1);
    check("restart_lat_a", {23'd0, if0.lat_a}, 64);
    check("restart_lat_b", {23'd0, if0.lat_b}, 64);
    check("restart_pass", {16'd0, if0.pass_count}, pc0);

    // Mutant core B: a mismatch is detected and stays flagged.
    launch(1, 6'd9, 6'd6);
    wait_done(1, 1'b0, bc);
    check("mut_result", {26'd0, if1.result}, 3);
    check("mut_nequiv", {31'd0, if1.nequiv}, 1);
    check("mut_pass", {16'd0, if1.pass_count}, 0);
    check("mut_lat_b", {23'd0, if1.lat_b}, lat_ref(9, 6, 1'b0));
    launch(1, 6'd12, 6'd8);
    wait_done(1, 1'b0, bc);
    check("mut2_result", {26'd0, if1.result}, 4);
    check("mut2_nequiv_sticky", {31'd0, if1.nequiv}, 1);

    // Short timeout: 63/1 needs far more than 8 RUN cycles.
    launch(2, 6'd63, 6'd1);
    wait_done(2, 1'b0, bc);
    check("to_busy_cycles", bc, 8);
    check("to_timeout", {31'd0, if2.timeout}, 1);
    check("to_result_kept", {26'd0, if2.result}, 0);
    check("to_pass", {16'd0, if2.pass_count}, 0);
    launch(2, 6'd12, 6'd8);
    wait_done(2, 1'b0, bc);
    check("to2_result", {26'd0, if2.result}, 4);
    check("to2_timeout_sticky", {31'd0, if2.timeout}, 1);
    check("to2_pass", {16'd0, if2.pass_count}, 1);
    check("to2_lat_b", {23'd0, if2.lat_b}, 5);

    // Reset in the middle of a run.
    launch(0, 6'd63, 6'd1);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_zero0("midreset");
    check("midreset_to2", {31'd0, if2.timeout}, 0);
    check("midreset_nq1", {31'd0, if1.nequiv}, 0);
    reset = 1'b0;
    pc0 = 0;
    run0(6'd21, 6'd14, 1'b0, 7, 4, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
